// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control, ALU and datapath.
package multicycle_control_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation select
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller state encodings (12..15 unused)
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // True for any opcode the controller knows how to sequence
  function automatic logic opcode_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct -> ALU operation, with a valid flag for unsupported functs.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  // Pure lookup; unknown functs default to ADD with valid low
  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     state_q, state_d;
  logic [2:0] fn_alu;
  logic       fn_valid;
  logic       decode_ok;
  logic       pcwrite, branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .alucontrol (fn_alu),
    .valid      (fn_valid)
  );

  // An R-type with an unsupported funct is as illegal as an unknown opcode
  assign decode_ok = opcode_known(opcode) && ((opcode != OP_RTYPE) || fn_valid);

  // State register; synchronous reset returns to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and Moore outputs; defaults first, then per-state overrides
  always_comb begin
    state_d      = S_FETCH;
    alucontrol   = ALU_ADD;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REG;
    iord         = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    pcsrc        = PCSRC_ALU;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb     = SRCB_FOUR;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm << 2) for a possible branch
        alusrcb = SRCB_IMMSH;
        if (!decode_ok) begin
          illegal_raw = 1'b1;
          state_d     = S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = fn_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every architectural side effect in the cycle it is held
  assign pcen       = (pcwrite | (branch & zero)) & ~reset;
  assign irwrite    = irwrite_raw  & ~reset;
  assign memwrite   = memwrite_raw & ~reset;
  assign regwrite   = regwrite_raw & ~reset;
  assign illegal_op = illegal_raw  & ~reset;
  assign state_dbg  = state_q;

endmodule
